// File: rtl/regfile_write_sched.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_sched
//  Purpose  : Serialises writeback records (up to two register writes each,
//             E then M) through a 4-entry FIFO onto a single registered
//             register-file write port. A non-AOK status stops intake, lets
//             the queue drain, then parks in HALTED until reset.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             in_valid/in_ready   - record handshake (accept at edge)
//             in_stat             - 0 bubble, 1 AOK, 2 HLT, 3 ADR, 4 INS
//             in_destE/in_destM   - destinations, values above 14 mean none
//             in_valE/in_valM     - write data
//             rf_we/rf_addr/rf_data - registered write port
//             pending_mask        - registers with a write still queued
//             busy                - queue non-empty
//             halt/halt_code      - sticky stop and the status that caused it
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_write_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_stat,
    input  logic [3:0]  in_destE,
    input  logic [3:0]  in_destM,
    input  logic [63:0] in_valE,
    input  logic [63:0] in_valM,
    output logic        rf_we,
    output logic [3:0]  rf_addr,
    output logic [63:0] rf_data,
    output logic [14:0] pending_mask,
    output logic        busy,
    output logic        halt,
    output logic [3:0]  halt_code
);

    localparam int unsigned DEPTH      = 4;
    localparam logic [3:0]  c_DEST_MAX = 4'd14;
    localparam logic [3:0]  c_STAT_BUB = 4'd0;
    localparam logic [3:0]  c_STAT_AOK = 4'd1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  addr_q [DEPTH];
    logic [63:0] data_q [DEPTH];
    logic [1:0]  head_q;
    logic [1:0]  tail_q;
    logic [2:0]  count_q;
    logic        rf_we_q;
    logic [3:0]  rf_addr_q;
    logic [63:0] rf_data_q;
    logic        halt_q;
    logic [3:0]  halt_code_q;

    logic        w_accept;
    logic        w_push_e;
    logic        w_push_m;
    logic        w_pop;
    logic        w_stop;
    logic [2:0]  w_push_cnt;
    logic [2:0]  count_d;
    logic [1:0]  head_d;
    logic [1:0]  tail_d;
    logic [1:0]  w_slot_m;
    logic [15:0] w_mask16;

    // Room for a full two-op record is required regardless of how many ops
    // the record actually carries; the pop of this cycle is not credited.
    assign in_ready = (state_q == ST_RUN) && (count_q <= 3'd2);
    assign w_accept = in_valid && in_ready;

    assign w_push_e = w_accept && (in_stat == c_STAT_AOK) && (in_destE <= c_DEST_MAX);
    assign w_push_m = w_accept && (in_stat == c_STAT_AOK) && (in_destM <= c_DEST_MAX);
    assign w_stop   = w_accept && (in_stat != c_STAT_AOK) && (in_stat != c_STAT_BUB);
    assign w_pop    = (count_q != 3'd0);

    assign w_push_cnt = {2'b00, w_push_e} + {2'b00, w_push_m};
    assign count_d    = count_q + w_push_cnt - {2'b00, w_pop};
    assign head_d     = head_q + {1'b0, w_pop};
    assign tail_d     = tail_q + w_push_cnt[1:0];
    // M lands after E when both are present, so a shared destination ends
    // with the M value.
    assign w_slot_m   = tail_q + {1'b0, w_push_e};

    // Only occupied slots contribute; the entry already on the rf outputs
    // has been popped and is no longer counted.
    always_comb begin
        w_mask16 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (3'(i) < count_q) begin
                w_mask16[addr_q[head_q + 2'(i)]] = 1'b1;
            end
        end
    end

    assign pending_mask = w_mask16[14:0];
    assign busy         = w_pop;
    assign rf_we        = rf_we_q;
    assign rf_addr      = rf_addr_q;
    assign rf_data      = rf_data_q;
    assign halt         = halt_q;
    assign halt_code    = halt_code_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            head_q      <= 2'd0;
            tail_q      <= 2'd0;
            count_q     <= 3'd0;
            rf_we_q     <= 1'b0;
            rf_addr_q   <= 4'd0;
            rf_data_q   <= 64'd0;
            halt_q      <= 1'b0;
            halt_code_q <= 4'd0;
        end else begin
            if (w_push_e) begin
                addr_q[tail_q] <= in_destE;
                data_q[tail_q] <= in_valE;
            end
            if (w_push_m) begin
                addr_q[w_slot_m] <= in_destM;
                data_q[w_slot_m] <= in_valM;
            end

            rf_we_q <= w_pop;
            if (w_pop) begin
                rf_addr_q <= addr_q[head_q];
                rf_data_q <= data_q[head_q];
            end

            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;

            case (state_q)
                ST_RUN: begin
                    if (w_stop) begin
                        halt_code_q <= in_stat;
                        state_q     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (count_q == 3'd0) begin
                        state_q <= ST_HALTED;
                        halt_q  <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_sched.md
REGFILE_WRITE_SCHED -- requirements
Module: regfile_write_sched

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset; sampled only on posedge clk.
REQ-003 SHALL have ports: in_valid  input  1  writeback record offered this cycle.
REQ-004 SHALL have ports: in_ready  output  1  record accepted at next edge when in_valid=1.
REQ-005 SHALL have ports: in_stat  input  4  record status (0 bubble, 1 AOK, 2 HLT, 3 ADR, 4 INS).
REQ-006 SHALL have ports: in_destE / in_destM  input  4 each  destination register; 4'hF = none.
REQ-007 SHALL have ports: in_valE / in_valM  input  64 each  write data.
REQ-008 SHALL have ports: rf_we  output  1  single register-file write strobe, registered.
REQ-009 SHALL have ports: rf_addr  output  4  write address, registered.
REQ-010 SHALL have ports: rf_data  output  64  write data, registered.
REQ-011 SHALL have ports: pending_mask  output  15  bit i = queue holds a write to register i (combinational from queue).
REQ-012 SHALL have ports: busy  output  1  queue non-empty.
REQ-013 SHALL have ports: halt  output  1  sticky stop indication.
REQ-014 SHALL have ports: halt_code  output  4  in_stat value that caused the stop.

Function
REQ-015 SHALL hold a 4-entry FIFO of write ops {addr[3:0], data[63:0]} with head/tail pointers wrapping mod 4 and a 3-bit count.
REQ-016 SHALL have states: RUN, DRAIN, HALTED.
REQ-017 SHALL drive in_ready = (state==RUN) && (4 - count >= 2), using count before this cycle's pop.
REQ-018 SHALL, on accept with in_stat==1: push E op if in_destE <= 14, then M op if in_destM <= 14, in that order into consecutive slots.
REQ-019 SHALL ignore dest values 15 (none) and treat any other value >14 as none.
REQ-020 SHALL make the M write win when in_destE == in_destM, since E is pushed first.
REQ-021 SHALL, on accept with in_stat==0, push nothing and leave state unchanged.
REQ-022 SHALL, on accept with in_stat in {2,3,4,other nonzero}, push nothing, latch halt_code <= in_stat, and enter DRAIN.
REQ-023 SHALL, each edge with count>0 (pre-edge), pop head and register rf_we=1, rf_addr, rf_data; otherwise register rf_we=0 and hold rf_addr/rf_data.
REQ-024 SHALL not bypass: an op pushed at edge N is popped at edge N+1 at the earliest; E-op strobe visible cycle N+1, M-op strobe cycle N+2.
REQ-025 SHALL allow simultaneous push and pop; count_next = count + pushes - pop; never exceeds 4.
REQ-026 SHALL transition DRAIN -> HALTED at the edge where count==0 pre-edge; halt=1 from that edge.
REQ-027 SHALL remain in HALTED, in_ready=0, halt=1, until reset.
REQ-028 SHALL compute pending_mask from valid FIFO entries only; the op currently on rf outputs is excluded.

Reset
REQ-029 SHALL, on reset=1 at an edge: empty the FIFO (count=0, pointers=0), state=RUN, rf_we=0, rf_addr=0, rf_data=0, halt=0, halt_code=0.
REQ-030 SHALL, on reset mid-operation, discard queued ops, issue no further rf writes, and give reset priority over any simultaneous accept.
REQ-031 SHALL have in_ready=1 in the first cycle after reset deasserts.

Verification
REQ-032 SHALL cover: reset, then accept {stat=1, destE=3, valE=0x55, destM=F} -> next cycle rf_we=1, addr=3, data=0x55; following cycle rf_we=0.
REQ-033 SHALL cover: accept {stat=1, destE=4, valE=0x100, destM=4, valM=0x20} (popq %rsp) -> writes (4,0x100) then (4,0x20) on consecutive cycles; pending_mask bit4 set until second pop.
REQ-034 SHALL cover: in_valid held with two-op records every cycle -> in_ready deasserts when count=3 or 4; no op lost or reordered; count never >4.
REQ-035 SHALL cover: 2 ops queued, then accept stat=3 -> in_ready=0 immediately; both ops written; halt=1 and halt_code=3 the edge after last pop; in_ready stays 0.
REQ-036 SHALL cover: reset asserted with 3 ops queued -> rf_we=0 next cycle, busy=0, pending_mask=0, halt=0.
REQ-037 SHALL cover: accept stat=0 with destE=2 -> no write, state RUN.
